// File: rtl/barshift_pkg.sv
// Shared constants and assembly-state encoding for the barrel-shifter operand loader.
package barshift_pkg;

    localparam int DATA_W  = 128;
    localparam int BEAT_W  = 32;
    localparam int SHAMT_W = 7;
    localparam int BEATS   = DATA_W / BEAT_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/barshift_operand_loader_if.sv
// Beat stream in, operand/shift-amount out, plus the sticky framing error flag.
interface barshift_operand_loader_if;
    import barshift_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [BEAT_W-1:0]  s_data;
    logic [SHAMT_W-1:0] s_shamt;
    logic               s_last;
    logic [DATA_W-1:0]  out0;
    logic [SHAMT_W-1:0] out1;
    logic               o_valid;
    logic               o_ready;
    logic               err;

    modport master (
        output s_valid, s_data, s_shamt, s_last, o_ready,
        input  s_ready, out0, out1, o_valid, err
    );

    modport slave (
        input  s_valid, s_data, s_shamt, s_last, o_ready,
        output s_ready, out0, out1, o_valid, err
    );

endinterface

// File: rtl/barshift_out_reg.sv
// One-entry valid/ready holding register feeding the shifter's in0/in1.
module barshift_out_reg
    import barshift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [SHAMT_W-1:0] load_shamt,
    input  logic               o_ready,
    output logic               slot_free,
    output logic               o_valid,
    output logic [DATA_W-1:0]  out0,
    output logic [SHAMT_W-1:0] out1
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;

    // Free when empty or being drained on this edge; load is only ever raised when free.
    assign slot_free = !valid_q || o_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            shamt_d = load_shamt;
        end else if (o_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
        end
    end

    assign o_valid = valid_q;
    assign out0    = data_q;
    assign out1    = shamt_q;

endmodule

// File: rtl/barshift_operand_loader.sv
// Assembles BEATS beats into one shifter operand with ping-pong buffering.
// Optional framing check on s_last: define BARSHIFT_LOADER_FRAMECHK_EN.
module barshift_operand_loader
    import barshift_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    barshift_operand_loader_if.slave bus
);

    loader_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;

    logic               beat_fire;
    logic               last_beat;
    logic               frame_bad;
    logic               slot_free;
    logic               load;
    logic [DATA_W-1:0]  merged;
    logic [DATA_W-1:0]  load_data;
    logic [SHAMT_W-1:0] beat_shamt;
    logic [SHAMT_W-1:0] load_shamt;

    assign bus.s_ready = rst_n && (state_q == FILL);
    assign beat_fire   = bus.s_valid && bus.s_ready;
    assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_shamt  = (cnt_q == '0) ? bus.s_shamt : shamt_q;

    // Stored beats with the incoming beat dropped into its slot.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slice
            assign merged[gi*BEAT_W +: BEAT_W] =
                (cnt_q == CNT_W'(gi)) ? bus.s_data : asm_q[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

`ifdef BARSHIFT_LOADER_FRAMECHK_EN
    logic err_q, err_d;

    assign frame_bad = beat_fire && (bus.s_last != last_beat);

    always_comb begin
        err_d = err_q || frame_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_last;

    assign unused_last = bus.s_last;
    assign frame_bad   = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        shamt_d    = shamt_q;
        load       = 1'b0;
        load_data  = merged;
        load_shamt = beat_shamt;
        case (state_q)
            FILL: begin
                if (beat_fire) begin
                    if (frame_bad) begin
                        cnt_d = '0;
                    end else begin
                        asm_d   = merged;
                        shamt_d = beat_shamt;
                        if (last_beat) begin
                            cnt_d = '0;
                            if (slot_free) begin
                                load = 1'b1;
                            end else begin
                                state_d = FULL;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            FULL: begin
                // Held operand moves across as soon as the output slot frees up.
                load_data  = asm_q;
                load_shamt = shamt_q;
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            shamt_q <= shamt_d;
        end
    end

    barshift_out_reg u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .load_shamt (load_shamt),
        .o_ready    (bus.o_ready),
        .slot_free  (slot_free),
        .o_valid    (bus.o_valid),
        .out0       (bus.out0),
        .out1       (bus.out1)
    );

endmodule

// File: tb/tb_barshift_operand_loader.sv
// Randomised and directed bench for barshift_operand_loader against a queue-level model.
module tb_barshift_operand_loader;
    import barshift_pkg::*;

`ifdef BARSHIFT_LOADER_FRAMECHK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    barshift_operand_loader_if bus();

    barshift_operand_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: completed operands not yet consumed (output slot + held assembly), at most 2.
    logic [DATA_W-1:0]  q_d[$];
    logic [SHAMT_W-1:0] q_s[$];
    logic [DATA_W-1:0]  m_asm;
    logic [SHAMT_W-1:0] m_sh;
    int                 m_idx;
    bit                 m_err;

    // Beat source, held until accepted.
    logic [BEAT_W-1:0]  src_d[$];
    logic [SHAMT_W-1:0] src_s[$];
    bit                 src_l[$];

    int dut_acc;
    int dut_ov;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [BEAT_W-1:0] d, input logic [SHAMT_W-1:0] sh, input bit l);
        src_d.push_back(d);
        src_s.push_back(sh);
        src_l.push_back(l);
    endtask

    task automatic push_op(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] sh, input int flip_pct);
        bit l;
        for (int k = 0; k < BEATS; k++) begin
            l = (k == BEATS - 1);
            if (FCHK) begin
                if (int'($urandom_range(99)) < flip_pct) l = !l;
            end else if (flip_pct > 0) begin
                l = $urandom_range(1);
            end
            push_beat(d[k*BEAT_W +: BEAT_W], sh, l);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_op();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_beat(input logic [BEAT_W-1:0] d, input logic [SHAMT_W-1:0] sh, input bit l);
        if (FCHK && (l != (m_idx == BEATS - 1))) begin
            m_err = 1'b1;
            m_idx = 0;
        end else begin
            m_asm[m_idx*BEAT_W +: BEAT_W] = d;
            if (m_idx == 0) m_sh = sh;
            if (m_idx == BEATS - 1) begin
                q_d.push_back(m_asm);
                q_s.push_back(m_sh);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("s_ready", bus.s_ready, q_d.size() < 2);
        chk("o_valid", bus.o_valid, q_d.size() > 0);
        if (q_d.size() > 0) begin
            chk("out0", bus.out0, q_d[0]);
            chk("out1", bus.out1, q_s[0]);
        end
        chk("err", bus.err, m_err);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
    task automatic step(input bit want_v, input bit ordy);
        bit v, acc, drn;
        v = want_v && (src_d.size() > 0);
        bus.s_valid = v;
        bus.s_data  = v ? src_d[0] : BEAT_W'($urandom);
        bus.s_shamt = v ? src_s[0] : SHAMT_W'($urandom);
        bus.s_last  = v ? src_l[0] : 1'b0;
        bus.o_ready = ordy;
        if (v && bus.s_ready) dut_acc++;
        @(posedge clk);
        acc = v && (q_d.size() < 2);
        drn = ordy && (q_d.size() > 0);
        if (drn) begin
            void'(q_d.pop_front());
            void'(q_s.pop_front());
        end
        if (acc) begin
            model_beat(src_d[0], src_s[0], src_l[0]);
            void'(src_d.pop_front());
            void'(src_s.pop_front());
            void'(src_l.pop_front());
        end
        @(negedge clk);
        check_outputs();
        if (bus.o_valid && ordy) dut_ov++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.o_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_out0", bus.out0, 0);
        chk("rst_out1", bus.out1, 0);
        chk("rst_err", bus.err, 0);
        q_d.delete(); q_s.delete();
        src_d.delete(); src_s.delete(); src_l.delete();
        m_asm = '0; m_sh = '0; m_idx = 0; m_err = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", bus.s_ready, 1);
    endtask

    logic [DATA_W-1:0] op_a, op_b;
    int bound;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_shamt = '0;
        bus.s_last  = 1'b0;
        bus.o_ready = 1'b0;
        rst_n = 1'b0;
        do_reset();

        // Basic operand, slot free, one-cycle latency.
        push_beat(32'h1, 7'd5, 1'b0);
        push_beat(32'h2, 7'd5, 1'b0);
        push_beat(32'h3, 7'd5, 1'b0);
        push_beat(32'h4, 7'd5, 1'b1);
        repeat (4) step(1'b1, 1'b1);
        chk("tp1_o_valid", bus.o_valid, 1);
        chk("tp1_out0", bus.out0, 128'h00000004_00000003_00000002_00000001);
        chk("tp1_out1", bus.out1, 7'd5);
        step(1'b0, 1'b1);

        // Back-pressure: 12 beats offered, only 8 fit.
        for (int i = 0; i < 3; i++) push_op(rand_op(), SHAMT_W'($urandom), 0);
        dut_acc = 0;
        repeat (12) step(1'b1, 1'b0);
        chk("bp_accepts", dut_acc, 8);
        chk("bp_stalled", bus.s_ready, 0);
        bound = 0;
        while ((src_d.size() > 0 || q_d.size() > 0) && bound < 40) begin
            step(1'b1, 1'b1);
            bound++;
        end
        chk("bp_drain_in_time", bound < 40, 1);
        chk("bp_total_accepts", dut_acc, 12);

        // Continuous stream, o_ready held high.
        push_op(rand_op(), 7'd0, 0);
        push_op(rand_op(), 7'd127, 0);
        push_op(rand_op(), 7'd64, 0);
        dut_acc = 0;
        dut_ov  = 0;
        repeat (12) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("cont_accepts", dut_acc, 12);
        chk("cont_pulses", dut_ov, 3);

        // Reset mid-operand with a full output slot.
        push_op(rand_op(), SHAMT_W'($urandom), 0);
        repeat (4) step(1'b1, 1'b0);
        push_op(rand_op(), SHAMT_W'($urandom), 0);
        repeat (2) step(1'b1, 1'b0);
        do_reset();
        op_a = rand_op();
        push_op(op_a, 7'd33, 0);
        repeat (4) step(1'b1, 1'b0);
        chk("postrst_out0", bus.out0, op_a);
        chk("postrst_out1", bus.out1, 7'd33);
        step(1'b0, 1'b1);

        // Final beat lands in the same cycle the output drains.
        op_a = rand_op();
        op_b = rand_op();
        push_op(op_a, 7'd10, 0);
        push_op(op_b, 7'd20, 0);
        dut_acc = 0;
        repeat (7) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("swap_accepts", dut_acc, 8);
        chk("swap_o_valid", bus.o_valid, 1);
        chk("swap_out0", bus.out0, op_b);
        chk("swap_out1", bus.out1, 7'd20);
        step(1'b0, 1'b1);

`ifdef BARSHIFT_LOADER_FRAMECHK_EN
        // Early s_last on beat 1 poisons the frame.
        push_beat(32'hAAAA0000, 7'd3, 1'b0);
        push_beat(32'hAAAA0001, 7'd3, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        chk("fchk_err", bus.err, 1);
        chk("fchk_no_valid", bus.o_valid, 0);
        op_a = rand_op();
        push_op(op_a, 7'd9, 0);
        repeat (4) step(1'b1, 1'b1);
        chk("fchk_recover_out0", bus.out0, op_a);
        chk("fchk_err_sticky", bus.err, 1);
        step(1'b0, 1'b1);
        do_reset();
`endif

        // Random traffic and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            if (src_d.size() < BEATS) push_op(rand_op(), SHAMT_W'($urandom), 8);
            step($urandom_range(3) != 0, $urandom_range(2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
